pe_link_tx: RTL and testbench
=============================

Name: pe_link_tx

Overview:
- Flit transmitter that drives one 130-bit mesh link into a neighbouring PE's in_from_* port.
- Accepts 128-bit words from a local producer over valid/ready and buffers them in an internal FIFO.
- Frames the words as flits on the link, under credit-based flow control returned by the receiving PE.
- Sits at the sending end of every PE-to-PE link in the overlay.

Parameters:
- LINK_WIDTH, 130, link width. Flit format: bit[129]=valid, bit[128]=last, bits[127:0]=payload.
- DATA_WIDTH, 128, payload width; must equal LINK_WIDTH-2.
- FIFO_ADDR_BITS, 4, FIFO depth is 2^FIFO_ADDR_BITS words (16 by default).
- CREDIT_INIT, 8, receiver buffer depth; credit count loaded at reset.
- CREDIT_BITS, 4, credit counter width; must hold CREDIT_INIT.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- ap_start  in  1  enable; a new packet may begin only while high.
- s_data  in  DATA_WIDTH  producer payload word.
- s_last  in  1  marks the final word of a packet.
- s_valid  in  1  producer word valid.
- s_ready  out  1  FIFO can accept a word.
- credit_in  in  1  one-cycle pulse from receiver; returns one credit.
- out_link  out  LINK_WIDTH  registered flit to the neighbour.
- busy  out  1  high while in SEND state.
- pkt_count  out  16  count of completed packets; wraps 0xFFFF->0.
- credit_err  out  1  sticky credit-overflow flag.
- stall_cycles  out  32  stall counter (see Optional Feature).

Behaviour:
- Reset (synchronous, one cycle is sufficient):
  - FIFO emptied; state=IDLE; credits=CREDIT_INIT.
  - out_link=0, busy=0, pkt_count=0, credit_err=0, stall_cycles=0.
  - Reset asserted mid-packet aborts the packet immediately; no last flit is emitted.
- Input side:
  - s_ready = !fifo_full.
  - A word is written when s_valid && s_ready; s_last is stored with the word.
  - s_ready is deasserted the cycle after the FIFO holds 2^FIFO_ADDR_BITS words.
  - A same-cycle pop frees space, but s_ready is registered from the occupancy count, so the freed slot is seen one cycle later.
- send condition = fifo not empty && credits>0 && state permits (see state machine).
- State machine:
  - IDLE -> SEND when ap_start=1 && fifo not empty && credits>0; the first flit is sent in that same cycle.
  - SEND: sends one flit per cycle while fifo not empty && credits>0; otherwise holds with out_link valid=0. ap_start is ignored in SEND, so a packet in progress always completes.
  - SEND -> IDLE in the cycle the flit with last=1 is sent; pkt_count increments in that cycle.
- Output:
  - out_link is registered: {1'b1, last, data} on a send cycle, all zeros otherwise.
  - Back-to-back flits are allowed.
- Latency: a word accepted at edge t, with an empty FIFO, IDLE state, ap_start=1 and credits>0, appears on out_link after edge t+2.
- Credits:
  - A send decrements the counter; a credit_in pulse increments it.
  - Send and credit_in in the same cycle leave the counter unchanged.
  - credit_in when credits=CREDIT_INIT and no send in that cycle: counter stays at CREDIT_INIT and credit_err is set; it clears only on reset.
  - At credits=0 no flit is sent; the FIFO keeps filling.
- busy = (state==SEND).

Optional Feature:
- Macro: PE_LINK_TX_STATS_EN.
- Defined: stall_cycles increments (saturating at 0xFFFFFFFF) every cycle that state==SEND && fifo not empty && credits==0.
- Undefined: stall_cycles is tied to 0 and the counter logic is removed. The port is present in both builds.

Test Plan:
- Reset: reset=1 for 2 cycles, with s_valid=1 -> out_link=0, s_ready=1 after reset, pkt_count=0, credit_err=0, busy=0.
- Single packet: ap_start=1; write words 0xA, 0xB, 0xC (last on 0xC) on consecutive cycles -> out_link shows 0x2_..._000A, then 0x2_..._000B, then 0x3_..._000C on consecutive cycles starting after edge t+2; pkt_count=1; credits read back 5.
- Credit stall (CREDIT_INIT=2): 4-word packet -> 2 flits sent, then valid=0 and busy=1. A credit_in pulse causes the 3rd flit the next cycle; a second pulse sends the 4th with last=1. With the STATS macro defined, stall_cycles equals the stalled cycle count.
- Simultaneous events: credit_in pulse in the same cycle as a send -> credit count unchanged. With credits=CREDIT_INIT and idle, a credit_in pulse -> credit_err=1 and stays high.
- FIFO full: ap_start=0; write 16 words -> s_ready=0 after the 16th; a 17th s_valid is not accepted; raising ap_start drains all 16 in order.
- ap_start dropped mid-packet: lower ap_start after the 1st flit of a 3-word packet -> the remaining 2 flits are still sent; a queued second packet is not started until ap_start=1.

Source files
------------

// File: rtl/pe_link_tx.sv
// Credit-flow flit transmitter: FIFO-buffers producer words and frames them onto a 130-bit mesh link.
// Optional stall statistics counter enabled by defining PE_LINK_TX_STATS_EN.
`default_nettype none

module pe_link_tx #(
   parameter int LINK_WIDTH     = 130,
   parameter int DATA_WIDTH     = 128,
   parameter int FIFO_ADDR_BITS = 4,
   parameter int CREDIT_INIT    = 8,
   parameter int CREDIT_BITS    = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ap_start,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_last,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic                  credit_in,
   output logic [LINK_WIDTH-1:0] out_link,
   output logic                  busy,
   output logic [15:0]           pkt_count,
   output logic                  credit_err,
   output logic [31:0]           stall_cycles
);

   localparam int AW = FIFO_ADDR_BITS;
   localparam logic [CREDIT_BITS-1:0] C_INIT = CREDIT_BITS'(CREDIT_INIT);

   typedef enum logic {S_IDLE, S_SEND} state_t;

   logic [DATA_WIDTH:0]   mem_q [2**AW];
   logic [AW:0]           wr_ptr_q, wr_vis_q, rd_ptr_q;
   state_t                state_q, state_d;
   logic [CREDIT_BITS-1:0] credit_q, credit_d;
   logic                  err_q, err_d;
   logic [15:0]           pkt_q, pkt_d;
   logic [LINK_WIDTH-1:0] link_q, link_d;
   logic                  push, send, avail, has_credit, full;
   logic [DATA_WIDTH:0]   head;

   // Extra wrap bit distinguishes full from empty; writes become readable one cycle
   // later through wr_vis_q, which gives the two-edge fill-to-link latency.
   assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign avail      = (wr_vis_q != rd_ptr_q);
   assign s_ready    = !full;
   assign push       = s_valid && !full;
   assign has_credit = (credit_q != '0);
   assign head       = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= {s_last, s_data};
   end

   always_comb begin
      state_d = state_q;
      send    = 1'b0;
      case (state_q)
         S_IDLE: if (ap_start && avail && has_credit) begin
            send    = 1'b1;
            state_d = head[DATA_WIDTH] ? S_IDLE : S_SEND;
         end
         S_SEND: if (avail && has_credit) begin
            send = 1'b1;
            if (head[DATA_WIDTH]) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      pkt_d  = (send && head[DATA_WIDTH]) ? pkt_q + 16'd1 : pkt_q;
      link_d = send ? {1'b1, head} : '0;
   end

   // Simultaneous send and return cancel; a return at full credit is an overflow.
   always_comb begin
      credit_d = credit_q;
      err_d    = err_q;
      if (send && !credit_in) begin
         credit_d = credit_q - 1'b1;
      end else if (!send && credit_in) begin
         if (credit_q == C_INIT) err_d = 1'b1;
         else                    credit_d = credit_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         wr_vis_q <= '0;
         rd_ptr_q <= '0;
         state_q  <= S_IDLE;
         credit_q <= C_INIT;
         err_q    <= 1'b0;
         pkt_q    <= '0;
         link_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, push};
         wr_vis_q <= wr_ptr_q;
         rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, send};
         state_q  <= state_d;
         credit_q <= credit_d;
         err_q    <= err_d;
         pkt_q    <= pkt_d;
         link_q   <= link_d;
      end
   end

   assign out_link   = link_q;
   assign busy       = (state_q == S_SEND);
   assign pkt_count  = pkt_q;
   assign credit_err = err_q;

`ifdef PE_LINK_TX_STATS_EN
   logic [31:0] stall_q;
   always_ff @(posedge clk) begin
      if (reset)
         stall_q <= '0;
      else if (state_q == S_SEND && avail && !has_credit && stall_q != 32'hFFFF_FFFF)
         stall_q <= stall_q + 32'd1;
   end
   assign stall_cycles = stall_q;
`else
   assign stall_cycles = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pe_link_tx.sv
// Directed self-checking bench for pe_link_tx with hand-computed flit expectations.
`default_nettype none

module tb_pe_link_tx;

   logic         clk = 1'b0;
   logic         reset, ap_start, s_last, s_valid, credit_in;
   logic [127:0] s_data;
   logic         s_ready, busy, credit_err;
   logic [129:0] out_link;
   logic [15:0]  pkt_count;
   logic [31:0]  stall_cycles;

   int checks = 0;
   int errors = 0;

`ifdef PE_LINK_TX_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   pe_link_tx dut (
      .clk(clk), .reset(reset), .ap_start(ap_start), .s_data(s_data), .s_last(s_last),
      .s_valid(s_valid), .s_ready(s_ready), .credit_in(credit_in), .out_link(out_link),
      .busy(busy), .pkt_count(pkt_count), .credit_err(credit_err), .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [129:0] obs, input logic [129:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [129:0] flit(input logic last, input logic [127:0] d);
      return {1'b1, last, d};
   endfunction

   function automatic logic [31:0] st(input int n);
      return STATS ? 32'(n) : 32'd0;
   endfunction

   initial begin
      reset = 1'b1; ap_start = 1'b0; s_valid = 1'b1; s_last = 1'b0;
      s_data = 128'h55; credit_in = 1'b0;
      tick(); tick();
      chk("rst_link", out_link, '0);
      chk("rst_busy", busy, 0);
      chk("rst_pkt", pkt_count, 0);
      chk("rst_err", credit_err, 0);
      chk("rst_stall", stall_cycles, 0);
      reset = 1'b0; s_valid = 1'b0;
      tick();
      chk("rst_ready", s_ready, 1);
      chk("rst_noflit", out_link, '0);

      // Single packet A,B,C
      ap_start = 1'b1;
      s_valid = 1'b1; s_data = 128'hA; s_last = 1'b0; tick();
      chk("lat_t0", out_link, '0);
      s_data = 128'hB; tick();
      chk("lat_t1", out_link, '0);
      s_data = 128'hC; s_last = 1'b1; tick();
      chk("flit_A", out_link, flit(1'b0, 128'hA));
      chk("busy_A", busy, 1);
      s_valid = 1'b0; s_last = 1'b0; tick();
      chk("flit_B", out_link, flit(1'b0, 128'hB));
      tick();
      chk("flit_C", out_link, flit(1'b1, 128'hC));
      chk("busy_C", busy, 0);
      chk("pkt_1", pkt_count, 1);
      tick();
      chk("idle_link", out_link, '0);
      chk("credits_5", dut.credit_q, 5);

      // Credit return coinciding with a send
      s_valid = 1'b1; s_data = 128'hD; s_last = 1'b1; tick();
      s_valid = 1'b0; s_last = 1'b0; tick();
      credit_in = 1'b1; tick();
      credit_in = 1'b0;
      chk("flit_D", out_link, flit(1'b1, 128'hD));
      chk("credits_same", dut.credit_q, 5);
      chk("pkt_2", pkt_count, 2);
      chk("err_still0", credit_err, 0);

      // Seven-word packet with five credits: stall then resume on returns
      for (int i = 0; i < 7; i++) begin
         s_valid = 1'b1; s_data = 128'h10 + 128'(i); s_last = (i == 6); tick();
         if (i >= 2) chk("stall_pre", out_link, flit(1'b0, 128'h10 + 128'(i - 2)));
      end
      s_valid = 1'b0; s_last = 1'b0;
      tick();
      chk("stall_v0", out_link, '0);
      chk("stall_busy", busy, 1);
      chk("stall_cnt1", stall_cycles, st(1));
      tick();
      chk("stall_cnt2", stall_cycles, st(2));
      credit_in = 1'b1; tick();
      credit_in = 1'b0;
      chk("stall_cnt3", stall_cycles, st(3));
      chk("stall_v0b", out_link, '0);
      tick();
      chk("flit_15", out_link, flit(1'b0, 128'h15));
      chk("stall_hold", stall_cycles, st(3));
      tick();
      chk("stall_v0c", out_link, '0);
      credit_in = 1'b1; tick();
      credit_in = 1'b0;
      chk("stall_cnt5", stall_cycles, st(5));
      tick();
      chk("flit_16", out_link, flit(1'b1, 128'h16));
      chk("busy_end", busy, 0);
      chk("pkt_3", pkt_count, 3);

      // Return all credits, then overflow
      credit_in = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      chk("credits_full", dut.credit_q, 8);
      chk("err_none", credit_err, 0);
      tick();
      credit_in = 1'b0;
      chk("err_set", credit_err, 1);
      chk("credits_sat", dut.credit_q, 8);
      tick(); tick();
      chk("err_sticky", credit_err, 1);

      // FIFO full with ap_start low
      ap_start = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (i == 15) chk("ready_15", s_ready, 1);
         s_valid = 1'b1; s_data = 128'h100 + 128'(i); s_last = (i == 7 || i == 15); tick();
      end
      chk("full_ready0", s_ready, 0);
      s_data = 128'hDEAD; s_last = 1'b1; tick();
      chk("full_ready0b", s_ready, 0);
      chk("full_nolink", out_link, '0);
      s_valid = 1'b0; s_last = 1'b0;
      ap_start = 1'b1; credit_in = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick();
         chk("drain", out_link, flit(i == 7 || i == 15, 128'h100 + 128'(i)));
      end
      credit_in = 1'b0;
      tick();
      chk("drain_empty", out_link, '0);
      chk("pkt_5", pkt_count, 5);
      chk("drain_ready", s_ready, 1);
      chk("drain_credits", dut.credit_q, 8);

      // ap_start dropped after the first flit
      for (int i = 0; i < 4; i++) begin
         s_valid = 1'b1;
         s_data  = (i < 3) ? 128'h20 + 128'(i) : 128'h30;
         s_last  = (i >= 2);
         tick();
         if (i == 2) begin
            chk("drop_f0", out_link, flit(1'b0, 128'h20));
            ap_start = 1'b0;
         end
      end
      chk("drop_f1", out_link, flit(1'b0, 128'h21));
      s_valid = 1'b0; s_last = 1'b0;
      tick();
      chk("drop_f2", out_link, flit(1'b1, 128'h22));
      chk("pkt_6", pkt_count, 6);
      tick();
      chk("drop_hold1", out_link, '0);
      tick();
      chk("drop_hold2", out_link, '0);
      chk("drop_idle", busy, 0);
      ap_start = 1'b1;
      tick();
      chk("second_pkt", out_link, flit(1'b1, 128'h30));
      chk("pkt_7", pkt_count, 7);
      tick();
      chk("final_idle", out_link, '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
